// File: rtl/sum3b_seq_pkg.sv
// rtl/sum3b_seq_pkg.sv - shared constants and state encoding for the slice-serial adder
// Purpose: slice width and FSM state type used by the interface, top and bench.
// Ports: none (package).
package sum3b_seq_pkg;

  localparam int SLICE_W = 3;

  // 2'd3 is unused and recovers to IDLE in the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sum3b_seq_if.sv
// rtl/sum3b_seq_if.sv - start/busy/done handshake and operand/result bus
// Purpose: groups the request side (start, a, b, ci) and result side (busy, done, so, co).
// Ports (modport master = requester, slave = adder):
//   start, a[W-1:0], b[W-1:0], ci : requester -> adder
//   busy, done, so[W-1:0], co     : adder -> requester
interface sum3b_seq_if
  import sum3b_seq_pkg::*;
#(
  parameter int NSLICE = 4
);

  localparam int W = SLICE_W * NSLICE;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] so;
  logic         co;

  modport master (output start, a, b, ci, input busy, done, so, co);
  modport slave  (input start, a, b, ci, output busy, done, so, co);

endinterface

// File: rtl/sum3b.sv
// rtl/sum3b.sv - 3-bit ripple-carry adder, the shared datapath of the sequencer
// Purpose: s_o/co_o = a_i + b_i + ci_i, purely combinational.
// Ports:
//   a_i[2:0], b_i[2:0] : addends
//   ci_i               : carry-in
//   s_o[2:0]           : sum
//   co_o               : carry-out
module sum3b (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic       ci_i,
  output logic [2:0] s_o,
  output logic       co_o
);

  always_comb begin : ripple
    logic [3:0] c;
    c    = 4'b0;
    c[0] = ci_i;
    s_o  = 3'b0;
    for (int i = 0; i < 3; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = c[3];
  end

endmodule

// File: rtl/sum3b_seq.sv
// rtl/sum3b_seq.sv - slice-serial adder: one 3-bit slice per clock through a shared sum3b
// Purpose: {co, so} = a + b + ci over W = 3*NSLICE bits, LSB slice first, start/busy/done handshake.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : sum3b_seq_if.slave (start/a/b/ci in; busy/done/so/co out, all registered)
module sum3b_seq
  import sum3b_seq_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic        clk,
  input  logic        rst,
  sum3b_seq_if.slave  bus
);

  localparam int                W        = SLICE_W * NSLICE;
  localparam int                IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       opa_q, opa_d;
  logic [W-1:0]       opb_q, opb_d;
  logic [W-1:0]       so_q, so_d;
  logic               carry_q, carry_d;
  logic               co_q, co_d;

  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic               c_out;

  // Operand slice select driven by the current slice index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = opa_q[i*SLICE_W +: SLICE_W];
        b_sl = opb_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  sum3b u_sum3b (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .ci_i (carry_q),
    .s_o  (s_sl),
    .co_o (c_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    so_d    = so_q;
    carry_d = carry_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.ci;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Only the slice under the index is rewritten; higher slices keep
        // the previous result until their turn.
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDX_W'(i)) so_d[i*SLICE_W +: SLICE_W] = s_sl;
        end
        carry_d = c_out;
        if (idx_q == IDX_LAST) begin
          co_d    = c_out;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      so_q    <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      so_q    <= so_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

  // Decoded straight from the state register, so busy and done are exclusive.
  assign bus.busy = (state_q == ADD);
  assign bus.done = (state_q == DONE);
  assign bus.so   = so_q;
  assign bus.co   = co_q;

endmodule
